// File: rtl/ysyx_22040759_wb_fifo_pkg.sv
// Shared definitions for the write-back buffer: register-write source
// encodings and the layout of the MEM->WB bus as functions of XLEN.
package ysyx_22040759_wb_fifo_pkg;

    // Source of the register-file write data for a retiring entry.
    typedef enum logic [1:0] {
        wreg_pc  = 2'b00,   // link value: pc + 4
        wreg_alu = 2'b01,   // ALU result
        wreg_ram = 2'b10,   // load data
        wreg_rsv = 2'b11    // reserved, writes nothing
    } wreg_sel_e;

    // Bus layout, MSB first:
    //   {reg_wen[1], rd[5], wreg_sel[2], rdata[XLEN], alu_result[XLEN], pc[XLEN]}
    localparam int RD_W  = 5;
    localparam int SEL_W = 2;

    function automatic int bus_width(input int xlen);
        return 3 * xlen + 8;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return 0 * xlen;
    endfunction

    function automatic int alu_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int rdata_lsb(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int sel_lsb(input int xlen);
        return 3 * xlen;
    endfunction

    function automatic int rd_lsb(input int xlen);
        return 3 * xlen + SEL_W;
    endfunction

    function automatic int wen_bit(input int xlen);
        return 3 * xlen + SEL_W + RD_W;
    endfunction

endpackage

// File: rtl/ysyx_22040759_fifo.sv
// Generic circular FIFO: storage, read/write pointers and occupancy count.
// The head word is read combinationally from storage, so a word written this
// cycle becomes visible at the head no earlier than the next cycle.
module ysyx_22040759_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr_nxt;
    logic [AW-1:0]    rptr_nxt;

    // Pointer advance with explicit wrap at DEPTH.
    always_comb begin
        wptr_nxt = (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
        rptr_nxt = (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
    end

    // Entry storage; not reset, stale words are never observed once count is 0.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and count; flush drops everything at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr_nxt;
            end
            if (pop) begin
                rptr <= rptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/ysyx_22040759_wb_fifo.sv
// Write-back stage buffer. Entries arriving from MEM are queued and retired
// in order into the register file, one per cycle while the write port is free.
//
// Handshake: an entry transfers on a rising edge when ms_to_ws_valid and
// ws_allowin are both high (and no flush). ws_allowin does not depend on
// ms_to_ws_valid; when full it is raised by rf_ready because the retiring head
// frees its slot in the same cycle. Retirement (ws_commit) happens when the
// buffer is non-empty, rf_ready is high and no flush is requested.
module ysyx_22040759_wb_fifo
    import ysyx_22040759_wb_fifo_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    localparam int BUS_W = 3 * XLEN + 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ms_to_ws_valid,
    input  logic [BUS_W-1:0]  ms_to_ws_bus,
    output logic              ws_allowin,
    input  logic              rf_ready,
    input  logic              ws_flush,
    output logic [XLEN+5:0]   ws_to_rf_bus,
    output logic [XLEN-1:0]   ws_pc,
    output logic              ws_commit,
    output logic [63:0]       ws_instret,
    output logic [CW-1:0]     ws_count
);

    logic [BUS_W-1:0] head;
    logic             has_entry;
    logic             push;
    logic             pop;

    logic             head_wen;
    logic [4:0]       head_rd;
    logic [1:0]       head_sel;
    logic [XLEN-1:0]  head_rdata;
    logic [XLEN-1:0]  head_alu;
    logic [XLEN-1:0]  head_pc;

    logic             rf_wen;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;

    ysyx_22040759_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (ws_flush),
        .wdata (ms_to_ws_bus),
        .rdata (head),
        .count (ws_count)
    );

    // Handshake and retire conditions.
    always_comb begin
        has_entry  = (ws_count != '0);
        ws_allowin = !ws_flush && ((ws_count < CW'(DEPTH)) || rf_ready);
        push       = ms_to_ws_valid && ws_allowin && !ws_flush;
        pop        = has_entry && rf_ready && !ws_flush;
        ws_commit  = pop;
    end

    // Split the head entry into its fields.
    always_comb begin
        head_wen   = head[wen_bit(XLEN)];
        head_rd    = head[rd_lsb(XLEN) +: RD_W];
        head_sel   = head[sel_lsb(XLEN) +: SEL_W];
        head_rdata = head[rdata_lsb(XLEN) +: XLEN];
        head_alu   = head[alu_lsb(XLEN) +: XLEN];
        head_pc    = head[pc_lsb(XLEN) +: XLEN];
    end

    // Register-file write port; everything reads as zero while empty so stale
    // storage never leaks out.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        ws_pc    = '0;
        if (has_entry) begin
            rf_waddr = head_rd;
            ws_pc    = head_pc;
            case (head_sel)
                wreg_pc:  rf_wdata = head_pc + XLEN'(4);
                wreg_alu: rf_wdata = head_alu;
                wreg_ram: rf_wdata = head_rdata;
                default:  rf_wdata = '0;
            endcase
            rf_wen = pop && head_wen && (head_rd != 5'd0) && (head_sel != wreg_rsv);
        end
        ws_to_rf_bus = {rf_wen, rf_waddr, rf_wdata};
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_instret <= '0;
        end else if (pop) begin
            ws_instret <= ws_instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_wb_fifo.sv
// Bench for the write-back buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ysyx_22040759_wb_fifo;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int BUS_W = 3 * XLEN + 8;
    localparam int CW    = $clog2(DEPTH + 1);

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              ms_to_ws_valid = 1'b0;
    logic [BUS_W-1:0]  ms_to_ws_bus = '0;
    logic              ws_allowin;
    logic              rf_ready = 1'b0;
    logic              ws_flush = 1'b0;
    logic [XLEN+5:0]   ws_to_rf_bus;
    logic [XLEN-1:0]   ws_pc;
    logic              ws_commit;
    logic [63:0]       ws_instret;
    logic [CW-1:0]     ws_count;

    ysyx_22040759_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ws_allowin     (ws_allowin),
        .rf_ready       (rf_ready),
        .ws_flush       (ws_flush),
        .ws_to_rf_bus   (ws_to_rf_bus),
        .ws_pc          (ws_pc),
        .ws_commit      (ws_commit),
        .ws_instret     (ws_instret),
        .ws_count       (ws_count)
    );

    // scoreboard
    logic [BUS_W-1:0] exp_q[$];
    logic [63:0]      exp_instret = '0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] mk(input logic wen, input logic [4:0] rd,
                                            input logic [1:0] sel, input logic [63:0] rdata,
                                            input logic [63:0] alu, input logic [63:0] pc);
        return {wen, rd, sel, rdata, alu, pc};
    endfunction

    // Register write value chosen by the entry's write-source code.
    function automatic logic [63:0] model_wdata(input logic [BUS_W-1:0] e);
        logic [63:0] pc, alu, rdata;
        pc    = e[63:0];
        alu   = e[127:64];
        rdata = e[191:128];
        case (e[193:192])
            2'd0:    return pc + 64'd4;
            2'd1:    return alu;
            2'd2:    return rdata;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit model_allow();
        return !ws_flush && ((exp_q.size() < DEPTH) || rf_ready);
    endfunction

    function automatic bit model_pop();
        return (exp_q.size() != 0) && rf_ready && !ws_flush;
    endfunction

    task automatic check_all();
        logic [BUS_W-1:0] h;
        logic             wen;
        logic [XLEN+5:0]  bus;
        h   = (exp_q.size() != 0) ? exp_q[0] : '0;
        wen = model_pop() && h[199] && (h[198:194] != 5'd0) && (h[193:192] != 2'd3);
        bus = (exp_q.size() != 0) ? {wen, h[198:194], model_wdata(h)} : '0;
        check("allowin", ws_allowin, model_allow());
        check("commit",  ws_commit, model_pop());
        check("rf_bus",  ws_to_rf_bus, bus);
        check("pc",      ws_pc, (exp_q.size() != 0) ? h[63:0] : 64'd0);
        check("count",   ws_count, exp_q.size());
        check("instret", ws_instret, exp_instret);
    endtask

    // driver: apply inputs away from the edge and check the settled outputs
    task automatic drive(input logic v, input logic [BUS_W-1:0] b, input logic rr, input logic fl);
        @(negedge clk);
        ms_to_ws_valid = v;
        ms_to_ws_bus   = b;
        rf_ready       = rr;
        ws_flush       = fl;
        #1;
        check_all();
    endtask

    // advance the model across the next rising edge
    task automatic tick();
        bit do_push, do_pop;
        do_push = ms_to_ws_valid && model_allow() && !ws_flush;
        do_pop  = model_pop();
        @(posedge clk);
        if (ws_flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                exp_instret++;
            end
            if (do_push) exp_q.push_back(ms_to_ws_bus);
        end
    endtask

    task automatic cycle(input logic v, input logic [BUS_W-1:0] b, input logic rr, input logic fl);
        drive(v, b, rr, fl);
        tick();
    endtask

    logic [BUS_W-1:0] e1, e2, e3, rb;

    initial begin
        // reset state
        #2;
        check("rst_allowin", ws_allowin, 1'b1);
        check("rst_commit", ws_commit, 1'b0);
        check("rst_bus", ws_to_rf_bus, '0);
        check("rst_pc", ws_pc, '0);
        check("rst_count", ws_count, '0);
        check("rst_instret", ws_instret, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // single ALU entry retires the cycle after it is pushed
        e1 = mk(1'b1, 5'd5, 2'b01, 64'hDEAD, 64'h1234, 64'h8000_0000);
        cycle(1'b1, e1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("alu_wen", ws_to_rf_bus[69], 1'b1);
        check("alu_waddr", ws_to_rf_bus[68:64], 5'd5);
        check("alu_wdata", ws_to_rf_bus[63:0], 64'h1234);
        check("alu_commit", ws_commit, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("alu_instret", ws_instret, 64'd1);
        tick();

        // pc+4 wraps to zero; rd=0 commits without writing
        e1 = mk(1'b1, 5'd0, 2'b00, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, e1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("pc4_wdata", ws_to_rf_bus[63:0], 64'd0);
        check("rd0_wen", ws_to_rf_bus[69], 1'b0);
        check("rd0_commit", ws_commit, 1'b1);
        tick();

        // stall with rf busy, third push blocked, then retire in order
        e1 = mk(1'b1, 5'd1, 2'b10, 64'h11, 64'h0, 64'h100);
        e2 = mk(1'b1, 5'd2, 2'b10, 64'h22, 64'h0, 64'h104);
        e3 = mk(1'b1, 5'd3, 2'b10, 64'h33, 64'h0, 64'h108);
        cycle(1'b1, e1, 1'b0, 1'b0);
        cycle(1'b1, e2, 1'b0, 1'b0);
        drive(1'b1, e3, 1'b0, 1'b0);
        check("full_allowin", ws_allowin, 1'b0);
        check("full_count", ws_count, 2'd2);
        tick();
        // full with push and pop together: count stays at 2
        cycle(1'b1, e3, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("swap_count", ws_count, 2'd2);
        check("order_2", ws_to_rf_bus[63:0], 64'h22);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("order_3", ws_to_rf_bus[63:0], 64'h33);
        tick();
        cycle(1'b0, '0, 1'b1, 1'b0);

        // flush two held entries
        cycle(1'b1, e1, 1'b0, 1'b0);
        cycle(1'b1, e2, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        check("flush_commit", ws_commit, 1'b0);
        check("flush_wen", ws_to_rf_bus[69], 1'b0);
        tick();
        drive(1'b1, e3, 1'b1, 1'b0);
        check("flush_count", ws_count, '0);
        tick();
        cycle(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rb = mk($urandom_range(0, 1), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
            cycle($urandom_range(0, 1), rb, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // asynchronous reset in the middle of a stall with two entries
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, e1, 1'b0, 1'b0);
        cycle(1'b1, e2, 1'b0, 1'b0);
        @(negedge clk);
        rf_ready = 1'b1;
        ms_to_ws_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", ws_count, '0);
        check("arst_instret", ws_instret, '0);
        check("arst_wen", ws_to_rf_bus[69], 1'b0);
        check("arst_commit", ws_commit, 1'b0);
        check("arst_allowin", ws_allowin, 1'b1);
        exp_q.delete();
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, e3, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
